// File: rtl/spi_master_128bit.sv
// rtl/spi_master_128bit.sv - SPI mode 0 master moving one 128-bit word per chip-select frame, MSB first
module spi_master_128bit #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 4,
  parameter int CS_HOLD  = 4,
  parameter int CS_IDLE  = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] tx_data,
  output logic         busy,
  output logic         done,
  output logic [127:0] rx_data,
  output logic         spi_sclk,
  output logic         spi_mosi,
  input  logic         spi_miso,
  output logic         spi_cs_n
);

  if (CLK_DIV < 4 || CLK_DIV > 65535) begin : g_bad_clk_div
    $error("spi_master_128bit: CLK_DIV must be in 4..65535");
  end
  if (CS_SETUP < 1 || CS_SETUP > 65535) begin : g_bad_cs_setup
    $error("spi_master_128bit: CS_SETUP must be in 1..65535");
  end
  if (CS_HOLD < 1 || CS_HOLD > 65535) begin : g_bad_cs_hold
    $error("spi_master_128bit: CS_HOLD must be in 1..65535");
  end
  if (CS_IDLE < 1 || CS_IDLE > 65535) begin : g_bad_cs_idle
    $error("spi_master_128bit: CS_IDLE must be in 1..65535");
  end

  localparam logic [15:0] DIV_LAST   = 16'(CLK_DIV - 1);
  localparam logic [15:0] SETUP_LAST = 16'(CS_SETUP - 1);
  localparam logic [15:0] HOLD_LAST  = 16'(CS_HOLD - 1);
  localparam logic [15:0] IDLE_LAST  = 16'(CS_IDLE - 1);
  localparam logic [7:0]  LAST_BIT   = 8'd127;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    XFER  = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } state_t;

  state_t       state;
  logic [15:0]  cnt;
  logic [7:0]   bit_cnt;
  logic [126:0] tx_sh;
  logic [127:0] rx_sh;
  logic [1:0]   miso_ff;

  // miso is asynchronous to clk; only miso_ff[1] is ever used
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miso_ff <= 2'b00;
    end else begin
      miso_ff <= {miso_ff[0], spi_miso};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= 16'd0;
      bit_cnt  <= 8'd0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      rx_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      spi_sclk <= 1'b0;
      spi_mosi <= 1'b0;
      spi_cs_n <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            tx_sh    <= tx_data[126:0];
            rx_sh    <= '0;
            bit_cnt  <= 8'd0;
            cnt      <= 16'd0;
            busy     <= 1'b1;
            spi_cs_n <= 1'b0;
            spi_mosi <= tx_data[127];
            state    <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == SETUP_LAST) begin
            cnt   <= 16'd0;
            state <= XFER;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        XFER: begin
          if (cnt == DIV_LAST) begin
            cnt      <= 16'd0;
            spi_sclk <= ~spi_sclk;
            // falling edge: sample at the end of the high phase, then launch the next bit
            if (spi_sclk) begin
              rx_sh   <= {rx_sh[126:0], miso_ff[1]};
              bit_cnt <= bit_cnt + 8'd1;
              if (bit_cnt == LAST_BIT) begin
                state <= HOLD;
              end else begin
                tx_sh    <= {tx_sh[125:0], 1'b0};
                spi_mosi <= tx_sh[126];
              end
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        HOLD: begin
          if (cnt == HOLD_LAST) begin
            cnt      <= 16'd0;
            spi_cs_n <= 1'b1;
            spi_mosi <= 1'b0;
            rx_data  <= rx_sh;
            done     <= 1'b1;
            state    <= GAP;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        GAP: begin
          if (cnt == IDLE_LAST) begin
            cnt   <= 16'd0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_128bit.sv
// tb/tb_spi_master_128bit.sv - directed bench for spi_master_128bit with loopback and shift-register slave
module tb_spi_master_128bit;

  localparam int CLK_DIV = 4;
  localparam logic [127:0] ONES = {128{1'b1}};
  localparam logic [127:0] A5S  = {16{8'hA5}};

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [127:0] tx_data;
  logic         busy;
  logic         done;
  logic [127:0] rx_data;
  logic         spi_sclk;
  logic         spi_mosi;
  logic         spi_miso;
  logic         spi_cs_n;

  int errors = 0;
  int checks = 0;

  logic         miso_mode = 1'b0;
  logic [127:0] slave_word = '0;
  logic [127:0] sl_sh = '0;
  logic         sl_in_frame = 1'b0;

  always #10 clk = ~clk;

  assign spi_miso = miso_mode ? sl_sh[127] : spi_mosi;

  spi_master_128bit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .tx_data  (tx_data),
    .busy     (busy),
    .done     (done),
    .rx_data  (rx_data),
    .spi_sclk (spi_sclk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .spi_cs_n (spi_cs_n)
  );

  // slave: loads on chip-select fall, presents MSB, shifts on each sclk fall
  always @(spi_cs_n or negedge spi_sclk) begin
    if (spi_cs_n) begin
      sl_in_frame = 1'b0;
    end else if (!sl_in_frame) begin
      sl_sh       = slave_word;
      sl_in_frame = 1'b1;
    end else if (!spi_sclk) begin
      sl_sh = {sl_sh[126:0], 1'b0};
    end
  end

  int cs_low_tot = 0, rise_tot = 0, viol_tot = 0, done_tot = 0;
  int run = 0, frame_rises = 0;
  logic p_sclk = 1'b0, p_cs = 1'b1, p_mosi = 1'b0;

  always @(negedge clk) begin
    if (!spi_cs_n) cs_low_tot++;
    if (done) done_tot++;
    if (spi_sclk && !p_sclk) rise_tot++;
    if (spi_cs_n) begin
      run = 0;
      frame_rises = 0;
    end else if (spi_sclk == p_sclk) begin
      run++;
    end else begin
      if ((p_sclk || frame_rises > 0) && run != CLK_DIV) viol_tot++;
      if (spi_sclk) frame_rises++;
      run = 1;
    end
    if (!spi_cs_n && !p_cs && spi_mosi !== p_mosi && !(p_sclk && !spi_sclk)) viol_tot++;
    p_sclk = spi_sclk;
    p_cs   = spi_cs_n;
    p_mosi = spi_mosi;
  end

  typedef struct {
    logic [127:0] tx;
    logic         use_bfm;
    logic [127:0] slave;
    logic [127:0] exp_rx;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", 128'(busy), 128'd0);
  endtask

  task automatic wait_done(input bit hold_start, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (!hold_start) start = 1'b0;
    end while (!done && cyc < 3000);
    if (!done) chk("done_timeout", 128'(done), 128'd1);
  endtask

  task automatic run_frame(input vec_t v, input string tag);
    int cyc, r0, c0, v0;
    miso_mode  = v.use_bfm;
    slave_word = v.slave;
    wait_idle();
    r0 = rise_tot;
    c0 = cs_low_tot;
    v0 = viol_tot;
    start   = 1'b1;
    tx_data = v.tx;
    wait_done(1'b0, cyc);
    chk({tag, "_latency"}, 128'(cyc), 128'd1033);
    chk({tag, "_rx"}, rx_data, v.exp_rx);
    chk({tag, "_rises"}, 128'(rise_tot - r0), 128'd128);
    chk({tag, "_cs_low"}, 128'(cs_low_tot - c0), 128'd1032);
    chk({tag, "_timing"}, 128'(viol_tot - v0), 128'd0);
    repeat (7) @(negedge clk);
    chk({tag, "_busy_gap"}, 128'(busy), 128'd1);
    @(negedge clk);
    chk({tag, "_busy_end"}, 128'(busy), 128'd0);
  endtask

  initial begin
    int cyc, d0, hi;
    vecs[0] = '{tx: 128'h0123456789ABCDEF_FEDCBA9876543210, use_bfm: 1'b0, slave: '0,
                exp_rx: 128'h0123456789ABCDEF_FEDCBA9876543210};
    vecs[1] = '{tx: 128'h0, use_bfm: 1'b1, slave: A5S, exp_rx: A5S};
    vecs[2] = '{tx: ONES, use_bfm: 1'b0, slave: '0, exp_rx: ONES};
    vecs[3] = '{tx: A5S, use_bfm: 1'b1, slave: 128'h80000000_00000000_00000000_00000001,
                exp_rx: 128'h80000000_00000000_00000000_00000001};
    vecs[4] = '{tx: 128'h1, use_bfm: 1'b0, slave: '0, exp_rx: 128'h1};

    rst_n   = 1'b0;
    start   = 1'b0;
    tx_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_cs_n", 128'(spi_cs_n), 128'd1);
    chk("rst_sclk", 128'(spi_sclk), 128'd0);
    chk("rst_mosi", 128'(spi_mosi), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_done", 128'(done), 128'd0);
    chk("rst_rx", rx_data, 128'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) run_frame(vecs[i], $sformatf("v%0d", i));

    // second start mid-frame must be ignored
    miso_mode = 1'b0;
    wait_idle();
    d0      = done_tot;
    start   = 1'b1;
    tx_data = 128'hDEADBEEF_00000000_12345678_9ABCDEF0;
    cyc     = 0;
    do begin
      @(negedge clk);
      cyc++;
      start = (cyc == 500);
      if (cyc == 500) tx_data = ONES;
    end while (!done && cyc < 3000);
    chk("t4_latency", 128'(cyc), 128'd1033);
    chk("t4_rx", rx_data, 128'hDEADBEEF_00000000_12345678_9ABCDEF0);
    repeat (20) @(negedge clk);
    chk("t4_done_count", 128'(done_tot - d0), 128'd1);
    chk("t4_no_requeue", 128'(busy), 128'd0);

    // reset in the middle of a frame
    start   = 1'b1;
    tx_data = ONES;
    @(negedge clk);
    start = 1'b0;
    repeat (299) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t5_cs_n", 128'(spi_cs_n), 128'd1);
    chk("t5_sclk", 128'(spi_sclk), 128'd0);
    chk("t5_busy", 128'(busy), 128'd0);
    chk("t5_rx", rx_data, 128'd0);
    chk("t5_done", 128'(done), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_frame(vecs[0], "t5_after");

    // back-to-back frames with start held high
    miso_mode = 1'b0;
    wait_idle();
    start   = 1'b1;
    tx_data = '0;
    @(negedge clk);
    tx_data = ONES;
    wait_done(1'b1, cyc);
    chk("t6_latency", 128'(cyc + 1), 128'd1033);
    chk("t6_rx0", rx_data, 128'd0);
    hi = 0;
    while (spi_cs_n && hi < 100) begin
      hi++;
      @(negedge clk);
    end
    chk("t6_cs_gap", 128'(hi), 128'd9);
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    chk("t6_latency2", 128'(cyc), 128'd1032);
    chk("t6_rx1", rx_data, ONES);
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
